divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new division; sampled on the rising edge.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 = two's-complement operands (div), 0 = unsigned (divu).
REQ-006 The block SHALL have port a, input, 32 bits: dividend.
REQ-007 The block SHALL have port b, input, 32 bits: divisor.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 The block SHALL have port quotient, output, 32 bits: result destined for LO.
REQ-011 The block SHALL have port remainder, output, 32 bits: result destined for HI.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: the last completed operation had b = 0.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 Start acceptance SHALL follow these rules:
- start is accepted only in IDLE or DONE.
- On acceptance the block latches is_signed, the operand signs, |a| and |b|, and b==0, then enters RUN with iteration count 32.
- a, b and is_signed are not required to be held after the accepting edge.
REQ-015 Each RUN cycle SHALL perform one restoring step:
- partial remainder = {partial remainder[31:0], next dividend MSB} (33-bit).
- Trial subtract |b|.
- If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
REQ-016 On the edge completing the 32nd iteration, the block SHALL write registered quotient/remainder with sign correction applied and go to DONE.
REQ-017 Sign correction (signed mode only) SHALL be as follows:
- quotient is negated when the operand signs differ.
- remainder takes the sign of the dividend.
- Quotient truncates toward zero.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle and busy SHALL be 0; the FSM returns to IDLE unless start is accepted in that cycle.
REQ-019 Latency SHALL be fixed: with start accepted at edge N, done is high in the cycle following edge N+32; busy is high in the cycles following edges N..N+31.
REQ-020 A start asserted while in RUN SHALL be ignored, with no effect on the operation in progress.
REQ-021 quotient, remainder and div_by_zero SHALL hold their last completed values until the next completion; they are not updated during RUN.
REQ-022 Divide by zero SHALL use the same 32-cycle latency and produce quotient = 0xFFFFFFFF, remainder = a (original bit pattern) and div_by_zero = 1, in either mode.
REQ-023 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL produce quotient = 0x80000000, remainder = 0 and div_by_zero = 0.
REQ-024 Magnitude arithmetic SHALL be 32-bit unsigned, with |0x80000000| = 0x80000000 (no overflow in the datapath).

Reset
REQ-025 When rst = 1 on a rising edge, the block SHALL go to IDLE and set busy = 0, done = 0, quotient = 0, remainder = 0 and div_by_zero = 0.
REQ-026 Reset SHALL take priority over start and over any in-progress operation; an aborted division never asserts done.
REQ-027 Start SHALL be accepted on the first edge after rst is deasserted.

Verification
REQ-028 The bench SHALL cover unsigned division: a=100, b=7, is_signed=0 -> done 32 cycles after accept, quotient=14, remainder=2, div_by_zero=0.
REQ-029 The bench SHALL cover signed division: a=0xFFFFFFF9 (-7), b=2, is_signed=1 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
REQ-030 The bench SHALL cover divide by zero: a=5, b=0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done still at 32 cycles.
REQ-031 The bench SHALL cover signed overflow: a=0x80000000, b=0xFFFFFFFF, is_signed=1 -> quotient=0x80000000, remainder=0.
REQ-032 The bench SHALL cover reset mid-operation: rst pulsed 10 cycles into RUN -> busy=0 next cycle, all outputs 0, no done pulse.
REQ-033 The bench SHALL cover start during RUN and back-to-back operations:
- start during RUN with new operands -> ignored; the original result appears at the original done cycle.
- start asserted in the DONE cycle -> accepted; busy=1 the following cycle.

Source files
------------

// File: rtl/divider.sv
// Iterative 32-bit restoring divider (signed/unsigned) with a fixed 32-cycle latency.
// Results are sign-corrected and registered on the final iteration, then held until the next completion.
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        zero_q, zero_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        dbz_q, dbz_d;

  logic [32:0] shifted_s;
  logic [33:0] trial_s;
  logic        qbit_s;
  logic [31:0] step_rem_s;
  logic [31:0] step_quo_s;
  logic        sign_a_s;
  logic        sign_b_s;

  // Next-state, datapath step and result formation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    // 34-bit trial so the borrow bit is unambiguous even when the shifted value exceeds 32 bits.
    shifted_s  = {rem_q, dvd_q[31]};
    trial_s    = {1'b0, shifted_s} - {2'b00, dvs_q};
    qbit_s     = ~trial_s[33];
    step_rem_s = qbit_s ? trial_s[31:0] : shifted_s[31:0];
    step_quo_s = {dvd_q[30:0], qbit_s};
    sign_a_s   = is_signed & a[31];
    sign_b_s   = is_signed & b[31];

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          cnt_d     = 6'd32;
          dvd_d     = cond_neg(a, sign_a_s);
          dvs_d     = cond_neg(b, sign_b_s);
          rem_d     = 32'd0;
          neg_quo_d = sign_a_s ^ sign_b_s;
          neg_rem_d = sign_a_s;
          zero_d    = (b == 32'd0);
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        dvd_d = step_quo_s;
        rem_d = step_rem_s;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = zero_q ? 32'hFFFF_FFFF : cond_neg(step_quo_s, neg_quo_q);
          // With a zero divisor every step subtracts nothing, so the remainder is |a| and restores to a.
          remainder_d = cond_neg(step_rem_s, neg_rem_q);
          dbz_d       = zero_q;
        end else begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      dvd_q       <= 32'd0;
      dvs_q       <= 32'd0;
      rem_q       <= 32'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

  divider_checker u_checker (
    .clk  (clk),
    .rst  (rst),
    .busy (busy_q),
    .done (done_q)
  );

endmodule

// Protocol properties for the divider handshake outputs.
module divider_checker (
  input logic clk,
  input logic rst,
  input logic busy,
  input logic done
);

  a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));
  a_done_single:    assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: the driver queues hand-computed results, a monitor checks each done pulse.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  divider dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez,
                       output int e);
    exp_t x;
    a = ta; b = tb_v; is_signed = ts; start = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    x.q = eq; x.r = er; x.z = ez; x.cyc = cyc + 32;
    exp_q.push_back(x);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; is_signed = ~ts;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_to(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation, at its cycle.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.z});
        chk("done_cycle", cyc, mon_e.cyc);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  localparam int NV = 9;
  logic [31:0] va [NV] = '{32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'hFFFF_FFF9,
                           32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFB, 32'h8000_0000};
  logic [31:0] vb [NV] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd2,
                           32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF};
  logic        vs [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] vq [NV] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFC,
                           32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'd0};
  logic [31:0] vr [NV] = '{32'd2, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd1,
                           32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000};
  logic        vz [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    // Back-to-back chain: each new start lands in the previous DONE cycle.
    for (int i = 0; i < NV; i++) begin
      issue(va[i], vb[i], vs[i], vq[i], vr[i], vz[i], e);
      if (i == 1) begin
        wait_to(e + 5);
        chk("hold_quotient", quotient, vq[0]);
        chk("hold_remainder", remainder, vr[0]);
        a = 32'd1; b = 32'd1; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_ignored_start", {31'd0, busy}, 32'd1);
      end
      wait_to(e + 32);
    end

    // Reset 10 cycles into a run: the division is dropped with no done pulse.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, e);
    wait_to(e + 10);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(32'd200, 32'd9, 1'b0, 32'd22, 32'd2, 1'b0, e);
    wait_to(e + 32);
    repeat (5) @(negedge clk);
    chk("all_results_seen", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
